// File: rtl/apb4_splitter.sv
// apb4_splitter: APB4 1-to-NUM_SLV splitter with base/mask decode and a registered downstream port.
// Define APB4_SPLIT_TIMEOUT_EN to enable the slave timeout counter and the tout_o pulse.
module apb4_splitter #(
  parameter int NUM_SLV        = 4,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter logic [NUM_SLV*APB_ADDR_WIDTH-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLV*APB_ADDR_WIDTH-1:0] SLV_MASK = '0,
  parameter int TIMEOUT_CYC    = 16
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [APB_ADDR_WIDTH-1:0]         s_paddr,
  input  logic [2:0]                        s_pprot,
  input  logic                              s_psel,
  input  logic                              s_penable,
  input  logic                              s_pwrite,
  input  logic [APB_DATA_WIDTH-1:0]         s_pwdata,
  input  logic [APB_DATA_WIDTH/8-1:0]       s_pstrb,
  output logic                              s_pready,
  output logic [APB_DATA_WIDTH-1:0]         s_prdata,
  output logic                              s_pslverr,
  output logic [APB_ADDR_WIDTH-1:0]         m_paddr,
  output logic [2:0]                        m_pprot,
  output logic                              m_pwrite,
  output logic [APB_DATA_WIDTH-1:0]         m_pwdata,
  output logic [APB_DATA_WIDTH/8-1:0]       m_pstrb,
  output logic [NUM_SLV-1:0]                m_psel,
  output logic                              m_penable,
  input  logic [NUM_SLV-1:0]                m_pready,
  input  logic [NUM_SLV*APB_DATA_WIDTH-1:0] m_prdata,
  input  logic [NUM_SLV-1:0]                m_pslverr,
  output logic                              tout_o
);

  localparam int AW    = APB_ADDR_WIDTH;
  localparam int DW    = APB_DATA_WIDTH;
  localparam int SW    = APB_DATA_WIDTH / 8;
  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DERR, RESP} state_e;

  state_e             state_d, state_q;
  logic [AW-1:0]      paddr_d, paddr_q;
  logic [2:0]         pprot_d, pprot_q;
  logic               pwrite_d, pwrite_q;
  logic [DW-1:0]      pwdata_d, pwdata_q;
  logic [SW-1:0]      pstrb_d, pstrb_q;
  logic [IDX_W-1:0]   idx_d, idx_q;
  logic [NUM_SLV-1:0] m_psel_d, m_psel_q;
  logic               m_penable_d, m_penable_q;
  logic               s_pready_d, s_pready_q;
  logic [DW-1:0]      s_prdata_d, s_prdata_q;
  logic               s_pslverr_d, s_pslverr_q;
  logic               tout_d, tout_q;

  logic               dec_hit;
  logic [IDX_W-1:0]   dec_idx;
  logic [NUM_SLV-1:0] dec_onehot;
  logic               to_hit;
  logic [DW-1:0]      slv_rdata [NUM_SLV];

  for (genvar g = 0; g < NUM_SLV; g++) begin : g_rdata
    assign slv_rdata[g] = m_prdata[g*DW +: DW];
  end

  // Scan from the top index down so the lowest matching slave overrides.
  always_comb begin
    dec_hit    = 1'b0;
    dec_idx    = '0;
    dec_onehot = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((s_paddr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        dec_hit       = 1'b1;
        dec_idx       = IDX_W'(i);
        dec_onehot    = '0;
        dec_onehot[i] = 1'b1;
      end
    end
  end

`ifdef APB4_SPLIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SETUP) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign to_hit = (cnt_q == CNT_LAST);
`else
  // Never times out: TIMEOUT_CYC is at least 2, so this is constant 0.
  assign to_hit = (TIMEOUT_CYC < 2);
`endif

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    idx_d       = idx_q;
    m_psel_d    = m_psel_q;
    m_penable_d = m_penable_q;
    s_pready_d  = 1'b0;
    s_prdata_d  = '0;
    s_pslverr_d = 1'b0;
    tout_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_psel && !s_penable) begin
          paddr_d  = s_paddr;
          pprot_d  = s_pprot;
          pwrite_d = s_pwrite;
          pwdata_d = s_pwdata;
          pstrb_d  = s_pstrb;
          idx_d    = dec_idx;
          if (dec_hit) begin
            m_psel_d = dec_onehot;
            state_d  = SETUP;
          end else begin
            state_d  = DERR;
          end
        end
      end
      SETUP: begin
        m_penable_d = 1'b1;
        state_d     = ACCESS;
      end
      ACCESS: begin
        // A ready slave wins over a timeout landing in the same cycle.
        if (m_pready[idx_q]) begin
          m_psel_d    = '0;
          m_penable_d = 1'b0;
          s_pready_d  = 1'b1;
          s_prdata_d  = slv_rdata[idx_q];
          s_pslverr_d = m_pslverr[idx_q];
          state_d     = RESP;
        end else if (to_hit) begin
          m_psel_d    = '0;
          m_penable_d = 1'b0;
          s_pready_d  = 1'b1;
          s_pslverr_d = 1'b1;
          tout_d      = 1'b1;
          state_d     = RESP;
        end
      end
      DERR: begin
        s_pready_d  = 1'b1;
        s_pslverr_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pprot_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      idx_q       <= '0;
      m_psel_q    <= '0;
      m_penable_q <= 1'b0;
      s_pready_q  <= 1'b0;
      s_prdata_q  <= '0;
      s_pslverr_q <= 1'b0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      idx_q       <= idx_d;
      m_psel_q    <= m_psel_d;
      m_penable_q <= m_penable_d;
      s_pready_q  <= s_pready_d;
      s_prdata_q  <= s_prdata_d;
      s_pslverr_q <= s_pslverr_d;
      tout_q      <= tout_d;
    end
  end

  assign m_paddr   = paddr_q;
  assign m_pprot   = pprot_q;
  assign m_pwrite  = pwrite_q;
  assign m_pwdata  = pwdata_q;
  assign m_pstrb   = pstrb_q;
  assign m_psel    = m_psel_q;
  assign m_penable = m_penable_q;
  assign s_pready  = s_pready_q;
  assign s_prdata  = s_prdata_q;
  assign s_pslverr = s_pslverr_q;
  assign tout_o    = tout_q;

endmodule

// File: tb/tb_apb4_splitter.sv
// tb_apb4_splitter: table-driven, hand-written and random transfers against a transaction-level model.
// Expectations for the timeout case follow the APB4_SPLIT_TIMEOUT_EN build setting.
module tb_apb4_splitter;

  localparam int NS      = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TO      = 16;
  localparam int MAX_CYC = 100;
`ifdef APB4_SPLIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // Slave 2 is a narrow window inside slave 3's range to exercise overlap priority.
  localparam logic [AW-1:0] BASE_TAB [NS] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h2000_0000};
  localparam logic [AW-1:0] MASK_TAB [NS] = '{32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000};
  localparam logic [NS*AW-1:0] BASE_P = {BASE_TAB[3], BASE_TAB[2], BASE_TAB[1], BASE_TAB[0]};
  localparam logic [NS*AW-1:0] MASK_P = {MASK_TAB[3], MASK_TAB[2], MASK_TAB[1], MASK_TAB[0]};

  logic             pclk;
  logic             preset;
  logic [AW-1:0]    s_paddr;
  logic [2:0]       s_pprot;
  logic             s_psel;
  logic             s_penable;
  logic             s_pwrite;
  logic [DW-1:0]    s_pwdata;
  logic [SW-1:0]    s_pstrb;
  logic             s_pready;
  logic [DW-1:0]    s_prdata;
  logic             s_pslverr;
  logic [AW-1:0]    m_paddr;
  logic [2:0]       m_pprot;
  logic             m_pwrite;
  logic [DW-1:0]    m_pwdata;
  logic [SW-1:0]    m_pstrb;
  logic [NS-1:0]    m_psel;
  logic             m_penable;
  logic [NS-1:0]    m_pready;
  logic [NS*DW-1:0] m_prdata;
  logic [NS-1:0]    m_pslverr;
  logic             tout_o;

  int checks = 0;
  int errors = 0;

  apb4_splitter #(
    .NUM_SLV(NS), .APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW),
    .SLV_BASE(BASE_P), .SLV_MASK(MASK_P), .TIMEOUT_CYC(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .s_paddr(s_paddr), .s_pprot(s_pprot), .s_psel(s_psel), .s_penable(s_penable),
    .s_pwrite(s_pwrite), .s_pwdata(s_pwdata), .s_pstrb(s_pstrb),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pprot(m_pprot), .m_pwrite(m_pwrite), .m_pwdata(m_pwdata),
    .m_pstrb(m_pstrb), .m_psel(m_psel), .m_penable(m_penable),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .tout_o(tout_o)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;
    logic [DW-1:0] rdata;
    logic          slv_err;
    logic [NS-1:0] exp_psel;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    int            exp_tout;
  } vec_t;

  typedef struct {
    logic [NS-1:0] psel_seen;
    int            lat;
    logic [DW-1:0] rdata;
    logic          err;
    int            tout_cnt;
    logic          req_bad;
    logic          idle_bad;
  } obs_t;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Transaction-level expectation: who answers, how long it takes, what comes back.
  function automatic vec_t refModel(input vec_t v);
    vec_t r = v;
    int   idx = -1;
    for (int i = 0; i < NS; i++)
      if (idx < 0 && (v.addr & MASK_TAB[i]) == BASE_TAB[i]) idx = i;
    r.exp_psel  = '0;
    r.exp_rdata = '0;
    r.exp_tout  = 0;
    r.exp_err   = 1'b0;
    if (idx < 0) begin
      r.exp_lat = 2;
      r.exp_err = 1'b1;
    end else begin
      r.exp_psel[idx] = 1'b1;
      if (TO_EN && v.waits >= TO) begin
        r.exp_lat  = 2 + TO;
        r.exp_err  = 1'b1;
        r.exp_tout = 1;
      end else begin
        r.exp_lat   = 3 + v.waits;
        r.exp_rdata = v.rdata;
        r.exp_err   = v.slv_err;
      end
    end
    return r;
  endfunction

  // Upstream master plus downstream slaves, driven and observed on the falling edge.
  task automatic applyStimulus(input vec_t v, output obs_t o);
    int sidx;
    int cyc;
    int acc;
    bit done;
    sidx = -1;
    for (int i = 0; i < NS; i++) if (v.exp_psel[i]) sidx = i;
    o.psel_seen = '0; o.lat = -1; o.rdata = '0; o.err = 1'b0;
    o.tout_cnt = 0; o.req_bad = 1'b0; o.idle_bad = 1'b0;
    @(negedge pclk);
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = v.addr; s_pwrite = v.write;
    s_pwdata = v.wdata; s_pstrb = v.strb; s_pprot = v.prot;
    cyc = 0; acc = 0; done = 1'b0;
    while (!done && cyc < MAX_CYC) begin
      @(negedge pclk);
      cyc++;
      s_penable = 1'b1;
      if (m_psel != '0) begin
        o.psel_seen |= m_psel;
        if (m_paddr !== v.addr || m_pwrite !== v.write || m_pwdata !== v.wdata ||
            m_pstrb !== v.strb || m_pprot !== v.prot) o.req_bad = 1'b1;
      end
      if (tout_o) o.tout_cnt++;
      if (s_pready) begin
        o.lat = cyc; o.rdata = s_prdata; o.err = s_pslverr; done = 1'b1;
      end else if (s_prdata !== '0 || s_pslverr !== 1'b0) begin
        o.idle_bad = 1'b1;
      end
      for (int i = 0; i < NS; i++) begin
        m_pready[i]  = 1'($urandom);
        m_pslverr[i] = 1'($urandom);
        m_prdata[i*DW +: DW] = $urandom;
      end
      if (sidx >= 0) begin
        m_pready[sidx]  = m_penable && (acc == v.waits);
        m_pslverr[sidx] = v.slv_err;
        m_prdata[sidx*DW +: DW] = v.rdata;
        if (m_penable) acc++;
      end
    end
    @(negedge pclk);
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0; m_pslverr = '0;
  endtask

  task automatic checkTransfer(input string tag, input vec_t v, input obs_t o);
    checkOutput({tag, ".psel"},  64'(o.psel_seen), 64'(v.exp_psel));
    checkOutput({tag, ".lat"},   64'(o.lat),       64'(v.exp_lat));
    checkOutput({tag, ".rdata"}, 64'(o.rdata),     64'(v.exp_rdata));
    checkOutput({tag, ".err"},   64'(o.err),       64'(v.exp_err));
    checkOutput({tag, ".tout"},  64'(o.tout_cnt),  64'(v.exp_tout));
    checkOutput({tag, ".req"},   64'(o.req_bad),   64'(0));
    checkOutput({tag, ".idle"},  64'(o.idle_bad),  64'(0));
  endtask

  vec_t tbl [8];
  vec_t v;
  obs_t o;

  initial begin
    //           addr          wr  wdata         strb     prot  waits rdata         serr  psel     lat rdata_exp     err tout
    tbl[0] = '{32'h1000_0004, 1'b1, 32'hDEADBEEF, 4'hF,    3'd0, 0,  32'h0000_0000, 1'b0, 4'b0010, 3,  32'h0000_0000, 1'b0, 0};
    tbl[1] = '{32'h2000_0008, 1'b0, 32'h0000_0000, 4'h0,   3'd1, 3,  32'h1234_5678, 1'b0, 4'b0100, 6,  32'h1234_5678, 1'b0, 0};
    tbl[2] = '{32'hF000_0000, 1'b0, 32'h0000_0000, 4'h0,   3'd0, 0,  32'h0000_0000, 1'b0, 4'b0000, 2,  32'h0000_0000, 1'b1, 0};
    tbl[3] = '{32'h2100_0000, 1'b0, 32'h0000_0000, 4'h0,   3'd0, 0,  32'hA5A5_A5A5, 1'b1, 4'b1000, 3,  32'hA5A5_A5A5, 1'b1, 0};
    tbl[4] = '{32'h2000_0010, 1'b1, 32'h55AA_55AA, 4'b0101, 3'd2, 1, 32'h0000_00FF, 1'b0, 4'b0100, 4,  32'h0000_00FF, 1'b0, 0};
    tbl[5] = '{32'h0000_0100, 1'b0, 32'h0000_0000, 4'h0,   3'd7, 2,  32'h0BAD_F00D, 1'b0, 4'b0001, 5,  32'h0BAD_F00D, 1'b0, 0};
    tbl[6] = '{32'h1FFF_FFFC, 1'b0, 32'h0000_0000, 4'h0,   3'd0, 15, 32'hCAFE_F00D, 1'b0, 4'b0010, 18, 32'hCAFE_F00D, 1'b0, 0};
    tbl[7] = '{32'h4000_0000, 1'b1, 32'h0102_0304, 4'h3,   3'd0, 0,  32'h0000_0000, 1'b0, 4'b0000, 2,  32'h0000_0000, 1'b1, 0};

    preset = 1'b1; s_paddr = '0; s_pprot = '0; s_psel = 1'b0; s_penable = 1'b0;
    s_pwrite = 1'b0; s_pwdata = '0; s_pstrb = '0;
    m_pready = '0; m_prdata = '0; m_pslverr = '0;
    repeat (2) @(negedge pclk);
    checkOutput("reset.m_psel",    64'(m_psel),    64'(0));
    checkOutput("reset.m_penable", 64'(m_penable), 64'(0));
    checkOutput("reset.s_pready",  64'(s_pready),  64'(0));
    checkOutput("reset.s_prdata",  64'(s_prdata),  64'(0));
    checkOutput("reset.s_pslverr", 64'(s_pslverr), 64'(0));
    checkOutput("reset.tout_o",    64'(tout_o),    64'(0));
    preset = 1'b0;

    for (int k = 0; k < 8; k++) begin
      applyStimulus(tbl[k], o);
      checkTransfer($sformatf("vec%0d", k), tbl[k], o);
    end

    // Slave that never answers on its own.
    v = '{32'h1000_0040, 1'b0, 32'h0, 4'h0, 3'd0, 0, 32'h1111_1111, 1'b0, 4'b0010, 0, 32'h0, 1'b0, 0};
    if (TO_EN) begin
      v.waits = 1000; v.exp_lat = 2 + TO; v.exp_rdata = '0; v.exp_err = 1'b1; v.exp_tout = 1;
    end else begin
      v.waits = 40; v.exp_lat = 43; v.exp_rdata = 32'h1111_1111; v.exp_err = 1'b0; v.exp_tout = 0;
    end
    applyStimulus(v, o);
    checkTransfer("timeout", v, o);
    checkOutput("timeout.after", 64'(tout_o), 64'(0));

    // Reset while the downstream access is in progress.
    @(negedge pclk);
    s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h2000_0020; s_pwrite = 1'b0;
    @(negedge pclk);
    s_penable = 1'b1;
    @(negedge pclk);
    checkOutput("rst.mid_psel", 64'(m_psel),    64'(4'b0100));
    checkOutput("rst.mid_pen",  64'(m_penable), 64'(1));
    preset = 1'b1;
    #1;
    checkOutput("rst.psel",   64'(m_psel),    64'(0));
    checkOutput("rst.pen",    64'(m_penable), 64'(0));
    checkOutput("rst.pready", 64'(s_pready),  64'(0));
    @(negedge pclk);
    preset = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    v = refModel('{32'h0000_0200, 1'b1, 32'h7777_8888, 4'hF, 3'd0, 1, 32'h600D_CAFE, 1'b0,
                   4'b0000, 0, 32'h0, 1'b0, 0});
    applyStimulus(v, o);
    checkTransfer("postrst", v, o);

    for (int k = 0; k < 40; k++) begin
      v.addr = $urandom;
      v.addr[31:28] = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 1) v.addr[27:16] = '0;
      v.write   = 1'($urandom);
      v.wdata   = $urandom;
      v.strb    = 4'($urandom);
      v.prot    = 3'($urandom);
      v.waits   = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(0, 3));
      v.rdata   = $urandom;
      v.slv_err = 1'($urandom);
      v = refModel(v);
      applyStimulus(v, o);
      checkTransfer($sformatf("rnd%0d", k), v, o);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
